// File: rtl/byte_rx_pkg.sv
// -----------------------------------------------------------------------------
// byte_rx_pkg
// Shared definitions for the byte_rx serial receiver: FSM state encoding,
// default frame geometry and the parity sense used when the optional parity
// bit (BYTE_RX_PARITY_EN) is compiled in.
// -----------------------------------------------------------------------------
package byte_rx_pkg;

   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_DATA_W       = 8;

   // Even parity: XOR of all data bits and the parity bit must be 0.
   localparam logic PARITY_SENSE = 1'b0;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_t;

   // data_xor is the reduction XOR of the received data bits.
   function automatic logic parity_ok(input logic data_xor, input logic pbit);
      return (data_xor ^ pbit) == PARITY_SENSE;
   endfunction

endpackage

// File: rtl/byte_rx_sync.sv
// -----------------------------------------------------------------------------
// byte_rx_sync
// Two-flop synchronizer for an asynchronous single-bit input. Flops reset to
// RST_VAL (default 1, the idle level of a serial line) so that reset never
// looks like a falling edge downstream.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   d    - asynchronous input
//   q    - synchronized output (two cycles of latency)
// -----------------------------------------------------------------------------
module byte_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/byte_rx.sv
// -----------------------------------------------------------------------------
// byte_rx
// Oversampling serial-to-parallel receiver. Frames start / DATA_W data bits
// (LSB first) / stop on an idle-high line and presents each correctly framed
// byte on data_out with a one-cycle load strobe. All registered outputs change
// only on rising clk edges, so a downstream falling-edge register sees them
// stable.
//
// Optional feature: define BYTE_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit, plus the parity_err output.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   rxd        - asynchronous serial input, idle high
//   data_out   - last correctly framed byte (held between loads)
//   load       - one-cycle pulse, data_out newly valid
//   busy       - high while a frame (or a break wait) is in progress
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse, parity mismatch (BYTE_RX_PARITY_EN only)
//
// state     | meaning
// ----------+----------------------------------------------------------------
// IDLE      | line idle, waiting for synchronized rxd to go low
// START     | timing to mid start bit; high there means a glitch
// DATA      | sampling DATA_W data bits at one-bit intervals
// PARITY    | sampling the parity bit (BYTE_RX_PARITY_EN only)
// STOP      | sampling the stop bit; decides load / error pulse
// WAIT_HIGH | stop bit was low (break); wait for line high before rearming
// -----------------------------------------------------------------------------
module byte_rx
   import byte_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_W       = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rxd,
   output logic [DATA_W-1:0] data_out,
   output logic              load,
   output logic              busy,
   output logic              frame_err
`ifdef BYTE_RX_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_W + 1);

   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   logic              rxs;
   rx_state_t         state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [IW-1:0]     idx, idx_nxt;
   logic [DATA_W-1:0] shift, shift_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              load_nxt;
   logic              ferr_nxt;
`ifdef BYTE_RX_PARITY_EN
   logic              par_bad, par_bad_nxt;
   logic              perr_nxt;
`endif

   byte_rx_sync #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxs)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         data_out  <= '0;
         load      <= 1'b0;
         frame_err <= 1'b0;
`ifdef BYTE_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shift     <= shift_nxt;
         data_out  <= data_nxt;
         load      <= load_nxt;
         frame_err <= ferr_nxt;
`ifdef BYTE_RX_PARITY_EN
         par_bad    <= par_bad_nxt;
         parity_err <= perr_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      idx_nxt   = idx;
      shift_nxt = shift;
      data_nxt  = data_out;
      load_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
`ifdef BYTE_RX_PARITY_EN
      par_bad_nxt = par_bad;
      perr_nxt    = 1'b0;
`endif

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rxs) begin
               state_nxt = START;
            end
         end

         // Sample at mid start bit; a high level here was only a glitch.
         START: begin
            if (cnt == CNT_HALF) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = rxs ? IDLE : DATA;
            end
         end

         // LSB arrives first, so shifting in at the MSB leaves bit 0 at
         // position 0 once all DATA_W bits are in.
         DATA: begin
            if (cnt == CNT_FULL) begin
               cnt_nxt   = '0;
               shift_nxt = {rxs, shift[DATA_W-1:1]};
               idx_nxt   = idx + IW'(1);
               if (idx == IDX_LAST) begin
`ifdef BYTE_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end

`ifdef BYTE_RX_PARITY_EN
         // Parity verdict is held until the stop sample so that a bad stop
         // bit can still override it.
         PARITY: begin
            if (cnt == CNT_FULL) begin
               cnt_nxt     = '0;
               par_bad_nxt = !parity_ok(^shift, rxs);
               state_nxt   = STOP;
            end
         end
`endif

         STOP: begin
            if (cnt == CNT_FULL) begin
               cnt_nxt = '0;
               if (rxs) begin
                  state_nxt = IDLE;
`ifdef BYTE_RX_PARITY_EN
                  if (par_bad) begin
                     perr_nxt = 1'b1;
                  end else begin
                     load_nxt = 1'b1;
                     data_nxt = shift;
                  end
`else
                  load_nxt = 1'b1;
                  data_nxt = shift;
`endif
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end

         // A held-low (break) line must not look like a new start bit.
         WAIT_HIGH: begin
            cnt_nxt = '0;
            if (rxs) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
